vend_coin_sequencer: RTL and testbench
======================================

# vend_coin_sequencer

Front-end controller for the Moore vending core. It accepts coin pulses from the two coin detectors, buffers them in a small FIFO and issues them to the core one at a time, respecting the core's register/state latency. It captures the core's item and change outputs and runs req/ack handshakes with the dispense motor and the change hopper. Coin issue is held off while a dispense is in progress.

## Interface
- FIFO_DEPTH, 4: coin FIFO entries (power of two, ≥2)
- GAP, 3: cycles in WAIT after a coin strobe (≥3; the core needs 2 cycles to reflect a coin plus 1 to return to S0)
- ACK_TIMEOUT, 255: max cycles in DISPENSE before fault (8-bit counter)
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state and outputs clear immediately on assertion
- coin5_in  in  1  one-cycle pulse, Rs5 coin detected
- coin10_in  in  1  one-cycle pulse, Rs10 coin detected
- coin_reject  out  1  one-cycle pulse: at least one coin this cycle was not accepted
- vend_rs5  out  1  registered one-cycle strobe to core rs5
- vend_rs10  out  1  registered one-cycle strobe to core rs10
- vend_item  in  1  core item1 output
- vend_chg  in  1  core rs5out (change) output
- motor_req  out  1  dispense-item request, level
- motor_ack  in  1  motor done
- chg_req  out  1  return-Rs5 request, level
- chg_ack  in  1  hopper done
- busy  out  1  state != IDLE or FIFO not empty
- fault  out  1  sticky handshake timeout
- sale_count  out  8  items dispensed, saturating

## Operation
- FIFO entry is 1 bit: 0 = Rs5, 1 = Rs10. Push and pop in the same cycle are allowed.
- Simultaneous coin5_in and coin10_in: Rs10 is enqueued first, then Rs5.
  - With free space ≥2, both are pushed.
  - With free space 1, Rs10 is pushed and Rs5 is rejected.
  - With free space 0, both are rejected.
- coin_reject pulses in the cycle after the rejected input.
- In FAULT, every coin is rejected.
- States:
  - IDLE: if the FIFO is not empty, pop the head and go to ISSUE.
  - ISSUE (1 cycle): drive vend_rs5 or vend_rs10 = 1 per the popped entry, then go to WAIT. The count is cleared and the item_pend/chg_pend latches are cleared.
  - WAIT (GAP cycles): set item_pend when vend_item=1 and set chg_pend when vend_chg=1, in any cycle. On exit, go to DISPENSE if either latch is set, else IDLE.
  - DISPENSE:
    - motor_req = item_pend and chg_req = chg_pend, asserted together.
    - On a sampled motor_ack=1, clear item_pend and increment sale_count (saturating at 255). chg_ack clears chg_pend the same way.
    - When both latches are clear, go to IDLE.
    - A timeout counter runs from entry. When it reaches ACK_TIMEOUT with a latch still set, go to FAULT.
  - FAULT: all reqs 0, fault=1, no coin issue. The FIFO is flushed. Exit only by reset.
- An ack arriving while the corresponding req is low is ignored.

## Timing
- Reset values: all outputs 0, FIFO empty, state IDLE, sale_count 0.
- Coin arriving at cycle t into an empty FIFO while IDLE:
  - pushed at edge t
  - popped and transitioned to ISSUE at t+1
  - strobe high during t+2
  - WAIT covers t+3 … t+2+GAP
- Minimum strobe-to-strobe spacing is GAP+2 cycles with no dispense.
- The req goes high the first cycle of DISPENSE. It drops the cycle after ack is sampled high. IDLE is entered the cycle after the last req drops.
- motor_ack and chg_ack arriving in the same cycle are both honored.
- Reset asserted mid-ISSUE/WAIT/DISPENSE: strobes and reqs drop asynchronously, and buffered coins are lost.

## Test plan
- Rs5, Rs5, Rs5 spaced 10 cycles -> three strobes on vend_rs5. The third WAIT sees vend_item=1, then motor_req; ack after 4 cycles -> sale_count=1, chg_req never asserted.
- coin10_in and coin5_in in the same cycle with the FIFO empty -> vend_rs10 strobe, then vend_rs5 strobe GAP+2 cycles later. No reject.
- 5 coins in consecutive cycles with the core model stalled in DISPENSE (FIFO_DEPTH=4) -> 4 accepted, exactly one coin_reject pulse. The remaining coins are issued in order after both acks.
- Rs10, Rs10 -> core reaches S20, so item and change are latched. motor_req and chg_req are asserted together; chg_ack at +2, motor_ack at +5 -> chg_req drops first, IDLE after motor_req drops, sale_count=1.
- motor_ack withheld -> fault=1 exactly ACK_TIMEOUT cycles after DISPENSE entry, reqs drop to 0. A later coin5_in gives a coin_reject pulse and no strobe.
- reset low during WAIT with 2 coins queued -> outputs 0 immediately. After release: FIFO empty, no strobes, sale_count=0.

Source files
------------

// File: rtl/vend_coin_sequencer.sv
// Coin front-end for the Moore vending core: buffers coin pulses, issues them one at a time
// with enough spacing for the core to settle, and runs the motor/hopper req/ack handshakes.
module vend_coin_sequencer #(
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned GAP         = 3,
  parameter int unsigned ACK_TIMEOUT = 255
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       coin5_in,
  input  logic       coin10_in,
  output logic       coin_reject,
  output logic       vend_rs5,
  output logic       vend_rs10,
  input  logic       vend_item,
  input  logic       vend_chg,
  output logic       motor_req,
  input  logic       motor_ack,
  output logic       chg_req,
  input  logic       chg_ack,
  output logic       busy,
  output logic       fault,
  output logic [7:0] sale_count
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DISPENSE,
    S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [FIFO_DEPTH-1:0] mem_q, mem_d;
  logic [AW-1:0]         rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  item_pend_q, item_pend_d;
  logic                  chg_pend_q, chg_pend_d;
  logic                  rs5_q, rs5_d, rs10_q, rs10_d;
  logic                  reject_q, reject_d;
  logic [7:0]            sale_q, sale_d;

  logic [CW-1:0] free;
  logic [AW-1:0] wr5Idx;
  logic          acc10, acc5, pop, head;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      mem_q       <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      count_q     <= '0;
      cnt_q       <= '0;
      item_pend_q <= 1'b0;
      chg_pend_q  <= 1'b0;
      rs5_q       <= 1'b0;
      rs10_q      <= 1'b0;
      reject_q    <= 1'b0;
      sale_q      <= '0;
    end else begin
      state_q     <= state_d;
      mem_q       <= mem_d;
      rd_q        <= rd_d;
      wr_q        <= wr_d;
      count_q     <= count_d;
      cnt_q       <= cnt_d;
      item_pend_q <= item_pend_d;
      chg_pend_q  <= chg_pend_d;
      rs5_q       <= rs5_d;
      rs10_q      <= rs10_d;
      reject_q    <= reject_d;
      sale_q      <= sale_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    mem_d       = mem_q;
    rd_d        = rd_q;
    wr_d        = wr_q;
    cnt_d       = cnt_q;
    item_pend_d = item_pend_q;
    chg_pend_d  = chg_pend_q;
    rs5_d       = 1'b0;
    rs10_d      = 1'b0;
    sale_d      = sale_q;
    acc10       = 1'b0;
    acc5        = 1'b0;
    pop         = 1'b0;
    head        = mem_q[rd_q];
    free        = CW'(FIFO_DEPTH) - count_q;

    // Rs10 wins the first free slot when both detectors fire together.
    if (state_q != S_FAULT) begin
      acc10 = coin10_in && (free != '0);
      if (coin5_in) begin
        acc5 = acc10 ? (free >= CW'(2)) : (free != '0);
      end
    end
    reject_d = (coin10_in && !acc10) || (coin5_in && !acc5);

    wr5Idx = acc10 ? (wr_q + AW'(1)) : wr_q;
    if (acc10) mem_d[wr_q] = 1'b1;
    if (acc5)  mem_d[wr5Idx] = 1'b0;
    wr_d = wr_q + AW'(acc10) + AW'(acc5);

    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          rs10_d  = head;
          rs5_d   = ~head;
          rd_d    = rd_q + AW'(1);
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        cnt_d       = '0;
        item_pend_d = 1'b0;
        chg_pend_d  = 1'b0;
        state_d     = S_WAIT;
      end
      S_WAIT: begin
        item_pend_d = item_pend_q | vend_item;
        chg_pend_d  = chg_pend_q | vend_chg;
        if (cnt_q == 8'(GAP - 1)) begin
          cnt_d   = '0;
          state_d = (item_pend_d || chg_pend_d) ? S_DISPENSE : S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      S_DISPENSE: begin
        // Leave only once both reqs have already been seen low for a cycle.
        if (!item_pend_q && !chg_pend_q) begin
          state_d = S_IDLE;
        end else begin
          if (item_pend_q && motor_ack) begin
            item_pend_d = 1'b0;
            if (sale_q != 8'hFF) sale_d = sale_q + 8'd1;
          end
          if (chg_pend_q && chg_ack) chg_pend_d = 1'b0;
          cnt_d = cnt_q + 8'd1;
          if ((cnt_q == 8'(ACK_TIMEOUT - 1)) && (item_pend_d || chg_pend_d)) begin
            state_d = S_FAULT;
          end
        end
      end
      S_FAULT: begin
        item_pend_d = 1'b0;
        chg_pend_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase

    count_d = count_q + CW'(acc10) + CW'(acc5) - CW'(pop);

    if (state_q == S_FAULT) begin
      count_d = '0;
      rd_d    = '0;
      wr_d    = '0;
    end
  end

  assign coin_reject = reject_q;
  assign vend_rs5    = rs5_q;
  assign vend_rs10   = rs10_q;
  assign motor_req   = (state_q == S_DISPENSE) && item_pend_q;
  assign chg_req     = (state_q == S_DISPENSE) && chg_pend_q;
  assign busy        = (state_q != S_IDLE) || (count_q != '0);
  assign fault       = (state_q == S_FAULT);
  assign sale_count  = sale_q;

endmodule

// File: tb/tb_vend_coin_sequencer.sv
// Directed bench for vend_coin_sequencer with a small behavioural model of the Moore vending
// core (registered coin inputs, one state register, item at 15, item plus change at 20).
module tb_vend_coin_sequencer;

   localparam int FIFO_DEPTH  = 4;
   localparam int GAP         = 3;
   localparam int ACK_TIMEOUT = 255;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       coin5_in, coin10_in, coin_reject;
   logic       vend_rs5, vend_rs10, vend_item, vend_chg;
   logic       motor_req, motor_ack, chg_req, chg_ack;
   logic       busy, fault;
   logic [7:0] sale_count;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int logKind[$];
   int logCyc[$];
   int rejectCount = 0;
   int lastRejectCyc = -1;
   int motorReqCycles = 0;
   int chgReqCycles = 0;

   always #5 clk = ~clk;

   vend_coin_sequencer #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .GAP(GAP),
      .ACK_TIMEOUT(ACK_TIMEOUT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .coin5_in(coin5_in),
      .coin10_in(coin10_in),
      .coin_reject(coin_reject),
      .vend_rs5(vend_rs5),
      .vend_rs10(vend_rs10),
      .vend_item(vend_item),
      .vend_chg(vend_chg),
      .motor_req(motor_req),
      .motor_ack(motor_ack),
      .chg_req(chg_req),
      .chg_ack(chg_ack),
      .busy(busy),
      .fault(fault),
      .sale_count(sale_count)
   );

   // Vending core model: strobe registered, then the running sum, which returns to zero after a sale.
   logic       coreRs5, coreRs10;
   logic [4:0] coreSum;
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         coreRs5  <= 1'b0;
         coreRs10 <= 1'b0;
         coreSum  <= 5'd0;
      end else begin
         coreRs5  <= vend_rs5;
         coreRs10 <= vend_rs10;
         if (coreSum >= 5'd15) coreSum <= 5'd0;
         else coreSum <= coreSum + (coreRs5 ? 5'd5 : 5'd0) + (coreRs10 ? 5'd10 : 5'd0);
      end
   end
   assign vend_item = (coreSum >= 5'd15);
   assign vend_chg  = (coreSum == 5'd20);

   always @(posedge clk) cyc <= cyc + 1;

   // Mid-cycle observer: logs every strobe with its cycle, plus reject pulses and req-high cycles.
   always @(negedge clk) begin
      if (vend_rs5) begin
         logKind.push_back(0);
         logCyc.push_back(cyc);
      end
      if (vend_rs10) begin
         logKind.push_back(1);
         logCyc.push_back(cyc);
      end
      if (coin_reject) begin
         rejectCount++;
         lastRejectCyc = cyc;
      end
      if (motor_req) motorReqCycles++;
      if (chg_req) chgReqCycles++;
   end

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
      end
   endtask

   function automatic int kindAt(input int i);
      return (i < logKind.size()) ? logKind[i] : -1;
   endfunction

   function automatic int cycAt(input int i);
      return (i < logCyc.size()) ? logCyc[i] : -1000;
   endfunction

   function automatic logic probe(input int sel);
      case (sel)
         0:       return motor_req;
         1:       return chg_req;
         2:       return fault;
         3:       return !busy;
         default: return 1'b0;
      endcase
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic waitCycles(input int n);
      repeat (n) step();
   endtask

   task automatic applyStimulus(input logic c5, input logic c10);
      coin5_in  = c5;
      coin10_in = c10;
      step();
      coin5_in  = 1'b0;
      coin10_in = 1'b0;
   endtask

   task automatic pulseAck(input logic m, input logic c);
      motor_ack = m;
      chg_ack   = c;
      step();
      motor_ack = 1'b0;
      chg_ack   = 1'b0;
   endtask

   // Returns at the negedge where the probed condition first holds, or after the budget expires.
   task automatic waitFor(input string tag, input int sel, input int budget);
      int n = 0;
      @(negedge clk);
      while (!probe(sel) && n < budget) begin
         @(negedge clk);
         n++;
      end
      checkOutput(tag, 32'(probe(sel)), 32'd1);
   endtask

   task automatic serviceMotor(input string tag, input int delay);
      waitFor(tag, 0, 60);
      step();
      waitCycles(delay - 1);
      pulseAck(1'b1, 1'b0);
   endtask

   initial begin
      #500000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int base, c0, rej0, mReq0, lastCoin, k;
      int expKinds[4] = '{1, 0, 1, 0};
      int tbKinds[5]  = '{1, 0, 1, 0, 0};

      coin5_in = 1'b0; coin10_in = 1'b0; motor_ack = 1'b0; chg_ack = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_strobes", {30'd0, vend_rs5, vend_rs10}, 32'd0);
      checkOutput("rst_reqs", {30'd0, motor_req, chg_req}, 32'd0);
      checkOutput("rst_busy", 32'(busy), 32'd0);
      checkOutput("rst_fault", 32'(fault), 32'd0);
      checkOutput("rst_reject", 32'(coin_reject), 32'd0);
      checkOutput("rst_sales", 32'(sale_count), 32'd0);
      step();
      reset = 1'b1;
      step();

      // Three Rs5 coins ten cycles apart; the third completes a sale.
      base = logKind.size();
      c0 = cyc;
      applyStimulus(1'b1, 1'b0);
      waitCycles(9);
      applyStimulus(1'b1, 1'b0);
      waitCycles(9);
      mReq0 = motorReqCycles;
      applyStimulus(1'b1, 1'b0);
      serviceMotor("t1_motor_req", 4);
      @(negedge clk);
      checkOutput("t1_req_drop", 32'(motor_req), 32'd0);
      checkOutput("t1_busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("t1_idle", 32'(busy), 32'd0);
      checkOutput("t1_strobe_count", 32'(logKind.size() - base), 32'd3);
      checkOutput("t1_all_rs5", 32'(kindAt(base) + kindAt(base + 1) + kindAt(base + 2)), 32'd0);
      checkOutput("t1_first_latency", 32'(cycAt(base) - c0), 32'd2);
      checkOutput("t1_spacing", 32'(cycAt(base + 1) - cycAt(base)), 32'd10);
      checkOutput("t1_req_cycles", 32'(motorReqCycles - mReq0), 32'd5);
      checkOutput("t1_no_chg_req", 32'(chgReqCycles), 32'd0);
      checkOutput("t1_sales", 32'(sale_count), 32'd1);
      step();

      // Simultaneous Rs10 and Rs5 into an empty FIFO.
      base = logKind.size();
      rej0 = rejectCount;
      c0 = cyc;
      applyStimulus(1'b1, 1'b1);
      serviceMotor("t2_motor_req", 1);
      waitFor("t2_idle", 3, 20);
      checkOutput("t2_first_rs10", 32'(kindAt(base)), 32'd1);
      checkOutput("t2_first_latency", 32'(cycAt(base) - c0), 32'd2);
      checkOutput("t2_second_rs5", 32'(kindAt(base + 1)), 32'd0);
      checkOutput("t2_spacing", 32'(cycAt(base + 1) - cycAt(base)), 32'(GAP + 2));
      checkOutput("t2_no_reject", 32'(rejectCount - rej0), 32'd0);
      checkOutput("t2_sales", 32'(sale_count), 32'd2);
      step();

      // Rs10 + Rs10: item and change together, change acked first.
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitFor("tA_motor_req", 0, 40);
      checkOutput("tA_chg_req_with_motor", 32'(chg_req), 32'd1);
      waitCycles(2);
      pulseAck(1'b0, 1'b1);
      @(negedge clk);
      checkOutput("tA_chg_drop", 32'(chg_req), 32'd0);
      checkOutput("tA_motor_hold", 32'(motor_req), 32'd1);
      waitCycles(2);
      pulseAck(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("tA_motor_drop", 32'(motor_req), 32'd0);
      checkOutput("tA_busy_hold", 32'(busy), 32'd1);
      @(negedge clk);
      checkOutput("tA_idle", 32'(busy), 32'd0);
      checkOutput("tA_sales", 32'(sale_count), 32'd3);
      step();

      // Five coins arrive while stalled in DISPENSE; the fifth overflows.
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b0, 1'b1);
      waitFor("tB_motor_req", 0, 40);
      checkOutput("tB_chg_req", 32'(chg_req), 32'd1);
      step();
      rej0 = rejectCount;
      base = logKind.size();
      lastCoin = 0;
      for (int i = 0; i < 5; i++) begin
         lastCoin = cyc;
         applyStimulus(tbKinds[i] == 0, tbKinds[i] == 1);
      end
      @(negedge clk);
      checkOutput("tB_reject_pulse", 32'(coin_reject), 32'd1);
      checkOutput("tB_stalled", 32'(motor_req), 32'd1);
      step();
      pulseAck(1'b1, 1'b1);
      @(negedge clk);
      checkOutput("tB_both_acks", {30'd0, motor_req, chg_req}, 32'd0);
      checkOutput("tB_sales_after_acks", 32'(sale_count), 32'd4);
      checkOutput("tB_reject_count", 32'(rejectCount - rej0), 32'd1);
      checkOutput("tB_reject_timing", 32'(lastRejectCyc - lastCoin), 32'd1);
      step();
      serviceMotor("tB_second_sale", 2);
      serviceMotor("tB_third_sale", 2);
      waitFor("tB_idle", 3, 20);
      checkOutput("tB_issued_count", 32'(logKind.size() - base), 32'd4);
      for (int i = 0; i < 4; i++) begin
         checkOutput($sformatf("tB_order_%0d", i), 32'(kindAt(base + i)), 32'(expKinds[i]));
      end
      checkOutput("tB_sales", 32'(sale_count), 32'd6);
      checkOutput("tB_no_more_rejects", 32'(rejectCount - rej0), 32'd1);
      step();

      // Withheld motor ack: fault after the timeout, coins then rejected.
      applyStimulus(1'b0, 1'b1);
      applyStimulus(1'b1, 1'b0);
      waitFor("tF_motor_req", 0, 40);
      k = 0;
      while (!fault && k < ACK_TIMEOUT + 20) begin
         @(negedge clk);
         k++;
      end
      checkOutput("tF_latency", 32'(k), 32'(ACK_TIMEOUT));
      checkOutput("tF_fault", 32'(fault), 32'd1);
      checkOutput("tF_reqs_low", {30'd0, motor_req, chg_req}, 32'd0);
      step();
      base = logKind.size();
      applyStimulus(1'b1, 1'b0);
      @(negedge clk);
      checkOutput("tF_reject", 32'(coin_reject), 32'd1);
      step();
      waitCycles(10);
      checkOutput("tF_no_strobe", 32'(logKind.size() - base), 32'd0);
      checkOutput("tF_sticky", 32'(fault), 32'd1);
      checkOutput("tF_sales", 32'(sale_count), 32'd6);

      // Reset clears the fault; then reset again mid-WAIT with two coins queued.
      reset = 1'b0;
      waitCycles(2);
      checkOutput("rs_fault_clear", 32'(fault), 32'd0);
      reset = 1'b1;
      step();
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      applyStimulus(1'b1, 1'b0);
      checkOutput("rs_busy_pre", 32'(busy), 32'd1);
      #2;
      reset = 1'b0;
      #1;
      checkOutput("rs_async_busy", 32'(busy), 32'd0);
      checkOutput("rs_async_outs", {26'd0, vend_rs5, vend_rs10, motor_req, chg_req, fault, coin_reject}, 32'd0);
      checkOutput("rs_async_sales", 32'(sale_count), 32'd0);
      waitCycles(2);
      reset = 1'b1;
      base = logKind.size();
      waitCycles(20);
      checkOutput("rs_no_strobe", 32'(logKind.size() - base), 32'd0);
      checkOutput("rs_idle", 32'(busy), 32'd0);
      checkOutput("rs_sales", 32'(sale_count), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
